// File: rtl/audio_codec_pkg.sv
// audio_codec_pkg: shared sample width, FIFO depth and stereo pair type for the codec bridge
package audio_codec_pkg;
  localparam int SAMPLE_W = 32;
  localparam int FIFO_DEPTH = 4;
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] l;
    logic signed [SAMPLE_W-1:0] r;
  } stereo_sample_t;
endpackage

// File: rtl/stereo_fifo.sv
// stereo_fifo: show-ahead FIFO of stereo pairs; a pop on a full FIFO frees room for a same-cycle push
module stereo_fifo
  import audio_codec_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_push,
  input  stereo_sample_t i_data,
  input  logic           i_pop,
  output stereo_sample_t o_data,
  output logic           o_full,
  output logic           o_empty
);
  localparam int AW = $clog2(DEPTH);
  stereo_sample_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_data = r_mem[r_rd];
  assign w_pop = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/audio_codec_if.sv
// audio_codec_if: I2S slave bridge between WM8731-style codec pins and the stereo sample FIFOs
module audio_codec_if
  import audio_codec_pkg::*;
#(
  parameter int SAMPLE_W   = audio_codec_pkg::SAMPLE_W,
  parameter int FIFO_DEPTH = audio_codec_pkg::FIFO_DEPTH
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       AUD_BCLK,
  input  logic                       AUD_ADCLRCK,
  input  logic                       AUD_ADCDAT,
  input  logic                       AUD_DACLRCK,
  output logic                       AUD_DACDAT,
  input  logic                       read_audio_in,
  output logic                       audio_in_available,
  output logic signed [SAMPLE_W-1:0] audio_in_L,
  output logic signed [SAMPLE_W-1:0] audio_in_R,
  input  logic                       write_audio_out,
  output logic                       audio_out_allowed,
  input  logic signed [SAMPLE_W-1:0] audio_out_L,
  input  logic signed [SAMPLE_W-1:0] audio_out_R,
  output logic                       adc_overrun,
  output logic                       dac_underrun
);
  logic [1:0] r_bclk_s, r_adclr_s, r_daclr_s, r_adcdat_s;
  logic r_bclk_d, r_adclr_d, r_daclr_d;
  logic w_bclk_rise, w_bclk_fall, w_adclr_rise, w_adclr_fall, w_daclr_rise, w_daclr_fall;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_bclk_s <= '0;
      r_adclr_s <= '0;
      r_daclr_s <= '0;
      r_adcdat_s <= '0;
      r_bclk_d <= 1'b0;
      r_adclr_d <= 1'b0;
      r_daclr_d <= 1'b0;
    end else begin
      r_bclk_s <= {r_bclk_s[0], AUD_BCLK};
      r_adclr_s <= {r_adclr_s[0], AUD_ADCLRCK};
      r_daclr_s <= {r_daclr_s[0], AUD_DACLRCK};
      r_adcdat_s <= {r_adcdat_s[0], AUD_ADCDAT};
      r_bclk_d <= r_bclk_s[1];
      r_adclr_d <= r_adclr_s[1];
      r_daclr_d <= r_daclr_s[1];
    end
  end
  assign w_bclk_rise = r_bclk_s[1] & ~r_bclk_d;
  assign w_bclk_fall = ~r_bclk_s[1] & r_bclk_d;
  assign w_adclr_rise = r_adclr_s[1] & ~r_adclr_d;
  assign w_adclr_fall = ~r_adclr_s[1] & r_adclr_d;
  assign w_daclr_rise = r_daclr_s[1] & ~r_daclr_d;
  assign w_daclr_fall = ~r_daclr_s[1] & r_daclr_d;
  // Receive: a one-hot mask walks MSB->LSB so short words stay left-justified and surplus bits fall off
  logic [SAMPLE_W-1:0] r_rx_word, r_rx_mask, r_rx_l;
  logic r_rx_skip, r_rx_armed, r_left_valid, r_adc_overrun;
  logic w_adc_push, w_adc_full, w_adc_empty;
  stereo_sample_t w_adc_in, w_adc_head;
  assign w_adc_push = w_adclr_fall & r_left_valid;
  assign w_adc_in = '{l: r_rx_l, r: r_rx_word};
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_rx_word <= '0;
      r_rx_mask <= '0;
      r_rx_l <= '0;
      r_rx_skip <= 1'b0;
      r_rx_armed <= 1'b0;
      r_left_valid <= 1'b0;
      r_adc_overrun <= 1'b0;
    end else begin
      if (w_adclr_rise | w_adclr_fall) begin
        r_rx_word <= '0;
        r_rx_mask <= {1'b1, {(SAMPLE_W-1){1'b0}}};
        r_rx_skip <= 1'b1;
        r_rx_armed <= 1'b1;
        if (w_adclr_rise & r_rx_armed) begin
          r_rx_l <= r_rx_word;
          r_left_valid <= 1'b1;
        end
      end else if (w_bclk_rise & r_rx_armed) begin
        r_rx_skip <= 1'b0;
        if (!r_rx_skip) begin
          r_rx_word <= r_rx_word | (r_adcdat_s[1] ? r_rx_mask : '0);
          r_rx_mask <= r_rx_mask >> 1;
        end
      end
      if (w_adc_push & w_adc_full & ~read_audio_in) r_adc_overrun <= 1'b1;
    end
  end
  stereo_fifo #(.DEPTH(FIFO_DEPTH)) u_adc_fifo (
    .clk(CLOCK_50), .rst(reset), .i_push(w_adc_push), .i_data(w_adc_in),
    .i_pop(read_audio_in), .o_data(w_adc_head), .o_full(w_adc_full), .o_empty(w_adc_empty)
  );
  assign audio_in_available = ~w_adc_empty;
  assign audio_in_L = w_adc_empty ? '0 : w_adc_head.l;
  assign audio_in_R = w_adc_empty ? '0 : w_adc_head.r;
  assign adc_overrun = r_adc_overrun;
  // Transmit: zero fill on shift means the line idles low once the word is exhausted
  logic [SAMPLE_W-1:0] r_tx_sh, r_hold_r;
  logic r_dacdat, r_dac_underrun;
  logic w_dac_full, w_dac_empty;
  stereo_sample_t w_dac_in, w_dac_head;
  assign w_dac_in = '{l: audio_out_L, r: audio_out_R};
  stereo_fifo #(.DEPTH(FIFO_DEPTH)) u_dac_fifo (
    .clk(CLOCK_50), .rst(reset), .i_push(write_audio_out), .i_data(w_dac_in),
    .i_pop(w_daclr_fall), .o_data(w_dac_head), .o_full(w_dac_full), .o_empty(w_dac_empty)
  );
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_tx_sh <= '0;
      r_hold_r <= '0;
      r_dacdat <= 1'b0;
      r_dac_underrun <= 1'b0;
    end else if (w_daclr_fall) begin
      r_tx_sh <= w_dac_empty ? '0 : w_dac_head.l;
      r_hold_r <= w_dac_empty ? '0 : w_dac_head.r;
      if (w_dac_empty) r_dac_underrun <= 1'b1;
    end else if (w_daclr_rise) begin
      r_tx_sh <= r_hold_r;
    end else if (w_bclk_fall) begin
      r_dacdat <= r_tx_sh[SAMPLE_W-1];
      r_tx_sh <= r_tx_sh << 1;
    end
  end
  assign AUD_DACDAT = r_dacdat;
  assign audio_out_allowed = ~w_dac_full;
  assign dac_underrun = r_dac_underrun;
endmodule

// File: tb/tb_audio_codec_if.sv
// tb_audio_codec_if: directed I2S frames in both directions with hand-computed expected words
module tb_audio_codec_if;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic AUD_BCLK = 1'b0;
  logic AUD_ADCLRCK = 1'b1;
  logic AUD_ADCDAT = 1'b0;
  logic AUD_DACLRCK = 1'b1;
  logic AUD_DACDAT;
  logic read_audio_in = 1'b0;
  logic audio_in_available;
  logic signed [31:0] audio_in_L, audio_in_R;
  logic write_audio_out = 1'b0;
  logic audio_out_allowed;
  logic signed [31:0] audio_out_L = '0;
  logic signed [31:0] audio_out_R = '0;
  logic adc_overrun, dac_underrun;
  int checks = 0;
  int errors = 0;
  audio_codec_if dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .AUD_BCLK(AUD_BCLK), .AUD_ADCLRCK(AUD_ADCLRCK),
    .AUD_ADCDAT(AUD_ADCDAT), .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
    .read_audio_in(read_audio_in), .audio_in_available(audio_in_available),
    .audio_in_L(audio_in_L), .audio_in_R(audio_in_R), .write_audio_out(write_audio_out),
    .audio_out_allowed(audio_out_allowed), .audio_out_L(audio_out_L), .audio_out_R(audio_out_R),
    .adc_overrun(adc_overrun), .dac_underrun(dac_underrun)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One BCLK period of 16 system clocks: pins change with the falling BCLK, DACDAT sampled at the rise
  task automatic slot(input logic lr, input logic d, input logic dlr, input logic wr, output logic cap);
    @(negedge CLOCK_50);
    AUD_BCLK = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_DACLRCK = dlr;
    AUD_ADCDAT = d;
    write_audio_out = wr;
    repeat (8) @(negedge CLOCK_50);
    write_audio_out = 1'b0;
    AUD_BCLK = 1'b1;
    cap = AUD_DACDAT;
    repeat (7) @(negedge CLOCK_50);
  endtask
  task automatic half(input logic lr, input logic [31:0] w, input logic dac_on, input logic wr,
                      input int lo, input int hi, inout logic [31:0] cap);
    for (int k = lo; k < hi; k++) begin
      logic c;
      slot(lr, (k >= 1 && k <= 32) ? w[32-k] : 1'b0, dac_on ? lr : 1'b1, wr && k == 0, c);
      if (k >= 1 && k <= 32) cap[32-k] = c;
    end
  endtask
  // Closing ADC LRCK fall with BCLK then parked low, so the next frame starts aligned
  task automatic end_fall();
    @(negedge CLOCK_50);
    AUD_BCLK = 1'b0;
    AUD_ADCLRCK = 1'b0;
    AUD_ADCDAT = 1'b0;
    repeat (16) @(negedge CLOCK_50);
  endtask
  task automatic frame(input logic [31:0] l, input logic [31:0] r, input logic dac_on, input logic wr,
                       output logic [31:0] cl, output logic [31:0] cr);
    cl = '0;
    cr = '0;
    half(1'b0, l, dac_on, wr, 0, 34, cl);
    half(1'b1, r, dac_on, 1'b0, 0, 34, cr);
    end_fall();
  endtask
  task automatic rd();
    @(negedge CLOCK_50);
    read_audio_in = 1'b1;
    @(negedge CLOCK_50);
    read_audio_in = 1'b0;
  endtask
  initial begin
    logic [31:0] cl, cr, pcap;
    logic [31:0] al [5];
    logic [31:0] ar [5];
    logic [31:0] dl [6];
    logic [31:0] dr [6];
    al = '{32'h00000001, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h80000001, 32'h0F0F0F0F};
    ar = '{32'h80000000, 32'h5A5A5A5A, 32'h00000000, 32'h7FFFFFFE, 32'hF0F0F0F0};
    dl = '{32'h80000000, 32'h11111111, 32'h22222222, 32'h33333333, 32'hC0FFEE00, 32'h0};
    dr = '{32'h7FFFFFFF, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'h00C0FFEE, 32'h0};
    repeat (3) @(negedge CLOCK_50);
    chk("rst_avail", 32'(audio_in_available), 32'd0);
    chk("rst_allowed", 32'(audio_out_allowed), 32'd1);
    chk("rst_inL", audio_in_L, 32'd0);
    chk("rst_inR", audio_in_R, 32'd0);
    chk("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
    chk("rst_ovr", 32'(adc_overrun), 32'd0);
    chk("rst_udr", 32'(dac_underrun), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    frame(32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0, cl, cr);
    chk("f1_avail", 32'(audio_in_available), 32'd1);
    chk("f1_L", audio_in_L, 32'h12345678);
    chk("f1_R", audio_in_R, 32'hDEADBEEF);
    rd();
    chk("f1_pop_avail", 32'(audio_in_available), 32'd0);
    chk("f1_pop_L", audio_in_L, 32'd0);
    chk("f1_pop_R", audio_in_R, 32'd0);
    for (int i = 0; i < 4; i++) frame(al[i], ar[i], 1'b0, 1'b0, cl, cr);
    chk("four_ovr", 32'(adc_overrun), 32'd0);
    frame(al[4], ar[4], 1'b0, 1'b0, cl, cr);
    chk("five_ovr", 32'(adc_overrun), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovr_L%0d", i), audio_in_L, al[i]);
      chk($sformatf("ovr_R%0d", i), audio_in_R, ar[i]);
      rd();
    end
    chk("ovr_drain_avail", 32'(audio_in_available), 32'd0);
    chk("ovr_sticky", 32'(adc_overrun), 32'd1);
    chk("pre_dac_udr", 32'(dac_underrun), 32'd0);
    @(negedge CLOCK_50);
    chk("dac_allowed0", 32'(audio_out_allowed), 32'd1);
    write_audio_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      audio_out_L = dl[i];
      audio_out_R = dr[i];
      if (i == 3) chk("dac_allowed3", 32'(audio_out_allowed), 32'd1);
      @(negedge CLOCK_50);
    end
    chk("dac_full", 32'(audio_out_allowed), 32'd0);
    audio_out_L = 32'hEEEEEEEE;
    audio_out_R = 32'hEEEEEEEE;
    @(negedge CLOCK_50);
    write_audio_out = 1'b0;
    chk("dac_full_ignored", 32'(audio_out_allowed), 32'd0);
    audio_out_L = dl[4];
    audio_out_R = dr[4];
    frame(32'h0, 32'h0, 1'b1, 1'b1, cl, cr);
    chk("tx0_L", cl, dl[0]);
    chk("tx0_R", cr, dr[0]);
    chk("tx_simul_full", 32'(audio_out_allowed), 32'd0);
    for (int i = 1; i < 5; i++) begin
      frame(32'h0, 32'h0, 1'b1, 1'b0, cl, cr);
      chk($sformatf("tx%0d_L", i), cl, dl[i]);
      chk($sformatf("tx%0d_R", i), cr, dr[i]);
    end
    chk("tx_drained_allowed", 32'(audio_out_allowed), 32'd1);
    chk("tx_no_udr", 32'(dac_underrun), 32'd0);
    frame(32'h0, 32'h0, 1'b1, 1'b0, cl, cr);
    chk("udr_L", cl, dl[5]);
    chk("udr_R", cr, dr[5]);
    chk("udr_flag", 32'(dac_underrun), 32'd1);
    chk("pre_rst_avail", 32'(audio_in_available), 32'd1);
    pcap = '0;
    half(1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 0, 10, pcap);
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    chk("mid_rst_avail", 32'(audio_in_available), 32'd0);
    chk("mid_rst_allowed", 32'(audio_out_allowed), 32'd1);
    chk("mid_rst_inL", audio_in_L, 32'd0);
    chk("mid_rst_ovr", 32'(adc_overrun), 32'd0);
    chk("mid_rst_udr", 32'(dac_underrun), 32'd0);
    chk("mid_rst_dacdat", 32'(AUD_DACDAT), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    half(1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 10, 34, pcap);
    half(1'b1, 32'h0BADF00D, 1'b0, 1'b0, 0, 34, pcap);
    end_fall();
    chk("partial_dropped", 32'(audio_in_available), 32'd0);
    frame(32'h13579BDF, 32'h2468ACE0, 1'b0, 1'b0, cl, cr);
    chk("post_rst_avail", 32'(audio_in_available), 32'd1);
    chk("post_rst_L", audio_in_L, 32'h13579BDF);
    chk("post_rst_R", audio_in_R, 32'h2468ACE0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
